// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Bit timing is a per-bit cycle counter; tx is registered so the pin never sees input glitches.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit (skipped when PARITY_EN=0)
// STOP   | stop bit (1); tx_done pulses on its final edge
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    shift_reg_q, shift_reg_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic          parity_bit_q, parity_bit_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic [2:0]    nxt_idx;

  assign bit_end = (clk_cnt_q == CNT_MAX);
  assign nxt_idx = bit_idx_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    shift_reg_d  = shift_reg_q;
    bit_idx_d    = bit_idx_q;
    clk_cnt_d    = clk_cnt_q;
    parity_bit_d = parity_bit_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_reg_d  = tx_data;
          parity_bit_d = (^tx_data) ^ (PARITY_ODD != 0);
          clk_cnt_d    = '0;
          state_d      = S_START;
          tx_d         = 1'b0;
          busy_d       = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = shift_reg_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = nxt_idx;
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // tx is registered, so load the upcoming bit one edge early
            tx_d = shift_reg_q[nxt_idx];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
          tx_d      = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  // tx resets to 1 so an aborted frame releases the line high without a low glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_reg_q  <= '0;
      bit_idx_q    <= '0;
      clk_cnt_q    <= '0;
      parity_bit_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      bit_idx_q    <= bit_idx_d;
      clk_cnt_q    <= clk_cnt_d;
      parity_bit_q <= parity_bit_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor decodes and checks them.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st  [3];
  logic [7:0] dat [3];
  logic       tx_w [3];
  logic       busy_w [3];
  logic       done_w [3];

  int   sel = 0;
  logic mon_tx, mon_busy, mon_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_total = 0;
  int last_done_cyc = -1000;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         len;
    bit         abort;
    int         gap;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .tx_start(st[0]), .tx_data(dat[0]),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .rst(rst), .tx_start(st[1]), .tx_data(dat[1]),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .tx_start(st[2]), .tx_data(dat[2]),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  always_comb begin
    mon_tx   = tx_w[0];
    mon_busy = busy_w[0];
    mon_done = done_w[0];
    if (sel == 1) begin
      mon_tx = tx_w[1]; mon_busy = busy_w[1]; mon_done = done_w[1];
    end else if (sel == 2) begin
      mon_tx = tx_w[2]; mon_busy = busy_w[2]; mon_done = done_w[2];
    end
  end

  always @(negedge clk) if (mon_done === 1'b1) done_total++;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Line monitor / receiver model
  initial begin : monitor
    exp_t e;
    int   errs [11];
    int   nb, k, start_cyc, busy_bad, done_early;
    bit   aborted;
    logic [7:0] rx;
    logic exp_bits [11];
    forever begin
      @(negedge clk);
      if (rst || mon_tx !== 1'b0) continue;
      start_cyc = cyc;
      if (exp_q.size() == 0) begin
        check(1'b0 ^ (exp_q.size() != 0), "unexpected_frame", 1, 0);
        for (int w = 0; w < 400 && mon_tx !== 1'b1; w++) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      if (e.gap >= 0) check(start_cyc - last_done_cyc == e.gap, "b2b_gap", start_cyc - last_done_cyc, e.gap);
      nb = e.len / 16;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[i+1] = e.data[i];
      exp_bits[9]  = (nb == 11) ? e.par : 1'b1;
      exp_bits[10] = 1'b1;
      for (int i = 0; i < 11; i++) errs[i] = 0;
      aborted = 0; busy_bad = 0; done_early = 0; rx = '0;
      for (int n = 0; n < e.len; n++) begin
        if (n > 0) @(negedge clk);
        if (rst) begin aborted = 1; break; end
        k = n / 16;
        if (mon_tx !== exp_bits[k]) errs[k]++;
        if (mon_busy !== 1'b1) busy_bad++;
        if (mon_done !== 1'b0) done_early++;
        if ((n % 16) == 8 && k >= 1 && k <= 8) rx[k-1] = mon_tx;
      end
      if (e.abort) begin
        check(aborted, "abort_by_reset", int'(aborted), 1);
        continue;
      end
      if (aborted) begin
        check(!aborted, "unexpected_abort", int'(aborted), 0);
        continue;
      end
      for (int i = 0; i < nb; i++) check(errs[i] == 0, $sformatf("bit%0d_cycles", i), errs[i], 0);
      check(rx == e.data, "rx_byte", int'(rx), int'(e.data));
      @(negedge clk);
      check(mon_done === 1'b1 && done_early == 0, "done_timing", done_early, 0);
      check(mon_busy === 1'b0 && busy_bad == 0, "busy_window", busy_bad, 0);
      last_done_cyc = cyc;
    end
  end

  task automatic send(input int s, input logic [7:0] d, input logic par, input int len,
                      input bit abort, input int gap);
    exp_t e;
    e.data = d; e.par = par; e.len = len; e.abort = abort; e.gap = gap;
    exp_q.push_back(e);
    st[s]  = 1'b1;
    dat[s] = d;
    @(negedge clk);
    st[s] = 1'b0;
    check(mon_tx === 1'b0 && mon_busy === 1'b1, "start_latency", int'(mon_tx), 0);
  endtask

  task automatic wait_done(input int limit);
    bit found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (mon_done === 1'b1) begin found = 1; break; end
    end
    check(found, "done_wait", int'(found), 1);
  endtask

  initial begin : stim
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; dat[i] = 8'h00; end

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check(tx_w[0] === 1'b1, "rst_tx", int'(tx_w[0]), 1);
    check(busy_w[0] === 1'b0, "rst_busy", int'(busy_w[0]), 0);
    check(done_w[0] === 1'b0, "rst_done", int'(done_w[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check(tx_w[0] === 1'b1, "post_rst_tx", int'(tx_w[0]), 1);
    check(busy_w[0] === 1'b0, "post_rst_busy", int'(busy_w[0]), 0);
    check(done_w[0] === 1'b0, "post_rst_done", int'(done_w[0]), 0);

    // 0x0C, even parity -> parity 0, 176-cycle frame
    sel = 0;
    send(0, 8'h0C, 1'b0, 176, 0, -1);
    wait_done(400);
    repeat (10) @(negedge clk);

    // 0x03 then 0x0E, second request in the tx_done cycle
    send(0, 8'h03, 1'b0, 176, 0, -1);
    wait_done(400);
    send(0, 8'h0E, 1'b1, 176, 0, 1);
    wait_done(400);
    repeat (10) @(negedge clk);

    // Request while busy is dropped
    send(0, 8'hA5, 1'b0, 176, 0, -1);
    repeat (50) @(negedge clk);
    st[0] = 1'b1; dat[0] = 8'hFF;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(400);
    repeat (250) @(negedge clk);
    check(done_total == 4, "done_count_busy", done_total, 4);

    // No parity: 0x81, 160-cycle frame
    sel = 1;
    send(1, 8'h81, 1'b0, 160, 0, -1);
    wait_done(400);
    repeat (10) @(negedge clk);

    // Odd parity: 0x0C -> parity 1
    sel = 2;
    send(2, 8'h0C, 1'b1, 176, 0, -1);
    wait_done(400);
    repeat (10) @(negedge clk);

    // Reset during bit 4 of 0x55 (frame cycles 80..95)
    sel = 0;
    send(0, 8'h55, 1'b0, 176, 1, -1);
    repeat (84) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check(tx_w[0] === 1'b1, "abort_tx", int'(tx_w[0]), 1);
    check(busy_w[0] === 1'b0, "abort_busy", int'(busy_w[0]), 0);
    check(done_w[0] === 1'b0, "abort_done", int'(done_w[0]), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(tx_w[0] === 1'b1, "abort_hold_tx", int'(tx_w[0]), 1);
    check(done_total == 6, "abort_no_done", done_total, 6);
    #2 rst = 1'b0;
    send(0, 8'h3C, 1'b0, 176, 0, -1);
    wait_done(400);
    repeat (20) @(negedge clk);

    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    check(done_total == 7, "done_total", done_total, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
